// File: rtl/image_stream_reader_pkg.sv
// image_pkg: shared types for the image stream reader.
//   rgb565_t       - BRAM word layout (r, g, b)
//   pixel_t        - one FIFO entry (gray, on, last, index)
//   state_t        - reader FSM states
//   rgb565_to_gray - 6-bit-weighted gray conversion, max 187, fits in 8 bits
package image_pkg;

  // Index field is wide enough for any supported frame; the reader
  // zero-extends its ADDR_W-bit address into it.
  localparam int unsigned IDX_W = 16;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // "on" holds the binarized pixel.
  typedef struct packed {
    logic [7:0]       gray;
    logic             on;
    logic             last;
    logic [IDX_W-1:0] index;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  function automatic logic [7:0] rgb565_to_gray(input rgb565_t w);
    return {2'b00, w.r, 1'b0} + {2'b00, w.g} + {2'b00, w.b, 1'b0};
  endfunction

endpackage

// File: rtl/image_stream_reader_pixel_fifo.sv
// pixel_fifo: synchronous FIFO with registered storage, no fall-through.
//   clk, reset - clock, synchronous active-high reset (flushes, zeroes storage)
//   push, din  - write request and data; accepted when not full or when
//                a pop happens in the same cycle
//   pop        - read request; ignored when empty
//   dout       - head entry, read straight from storage flops
//   full, empty, count - occupancy
// DEPTH must be a power of two (pointers wrap naturally).
module pixel_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/image_stream_reader.sv
// image_stream_reader: streams a captured RGB565 frame out of BRAM as
// gray + binarized pixels over valid/ready, counting "on" pixels.
//   clk, reset         - single clock, synchronous active-high reset
//   start, threshold   - frame request (honoured in IDLE), gray threshold
//   busy, done         - frame in progress / one-cycle completion pulse
//   bram_en/addr/dout  - BRAM read port, data READ_LAT cycles after enable
//   m_valid, m_ready   - output handshake
//   m_gray, m_bit, m_last, m_index - current output pixel
//   on_count           - handshaken on-pixel count for the current frame
// Reads are credit-limited so FIFO entries plus reads in flight never
// exceed FIFO_DEPTH; every issued read therefore has a FIFO slot.
module image_stream_reader
  import image_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned N_PIXELS   = 1024,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        threshold,
  output logic              busy,
  output logic              done,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [15:0]       bram_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_gray,
  output logic              m_bit,
  output logic              m_last,
  output logic [ADDR_W-1:0] m_index,
  output logic [ADDR_W:0]   on_count
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIXELS - 1);

  state_t            state;
  logic [7:0]        thr_q;
  logic [ADDR_W-1:0] addr;

  // Read-return pipeline: marks which cycles carry valid BRAM data.
  logic [READ_LAT-1:0] rd_vld;
  logic [ADDR_W-1:0]   rd_idx [READ_LAT];
  logic [CW-1:0]       inflight;

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [CW:0]   credit_used;
  logic          issue;
  logic          drain_done;
  pixel_t        wr_pix;
  pixel_t        head;
  logic [$bits(pixel_t)-1:0] fifo_dout;
  logic          unused_ok;

  always_comb begin
    credit_used = (CW+1)'(fifo_count) + (CW+1)'(inflight) + (CW+1)'(1);
    issue       = (state == RUN) && (credit_used <= (CW+1)'(FIFO_DEPTH));
  end

  assign bram_en   = issue;
  assign bram_addr = addr;

  assign push = rd_vld[READ_LAT-1];
  assign pop  = !fifo_empty && m_ready;

  // A pop of the last entry in this cycle counts as empty, so done follows
  // the final handshake directly.
  assign drain_done = (inflight == '0) &&
                      ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));

  always_comb begin
    wr_pix = '0;
    wr_pix.gray = rgb565_to_gray(rgb565_t'(bram_dout));
    wr_pix.on   = (wr_pix.gray >= thr_q);
    wr_pix.last = (rd_idx[READ_LAT-1] == LAST_ADDR);
    wr_pix.index[ADDR_W-1:0] = rd_idx[READ_LAT-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld   <= '0;
      inflight <= '0;
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        rd_idx[i] <= '0;
      end
    end else begin
      rd_vld[0] <= issue;
      rd_idx[0] <= addr;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        rd_vld[i] <= rd_vld[i-1];
        rd_idx[i] <= rd_idx[i-1];
      end
      inflight <= inflight + CW'(issue) - CW'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      addr     <= '0;
      thr_q    <= '0;
      on_count <= '0;
    end else begin
      done <= 1'b0;
      if (pop && head.on) begin
        on_count <= on_count + (ADDR_W+1)'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            addr     <= '0;
            thr_q    <= threshold;
            on_count <= '0;
          end
        end
        RUN: begin
          if (issue) begin
            addr <= addr + ADDR_W'(1);
            if (addr == LAST_ADDR) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(pixel_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (wr_pix),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head     = pixel_t'(fifo_dout);
  assign m_valid  = !fifo_empty;
  assign m_gray   = head.gray;
  assign m_bit    = head.on;
  assign m_last   = head.last;
  assign m_index  = head.index[ADDR_W-1:0];

  assign unused_ok = fifo_full ^ (^head.index);

endmodule

// File: tb/tb_image_stream_reader.sv
module tb_image_stream_reader;

  localparam int AW    = 10;
  localparam int N     = 1024;
  localparam int RL    = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    threshold = '0;
  logic          busy, done, bram_en;
  logic [AW-1:0] bram_addr;
  logic [15:0]   bram_dout;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [7:0]    m_gray;
  logic          m_bit, m_last;
  logic [AW-1:0] m_index;
  logic [AW:0]   on_count;

  image_stream_reader #(
    .ADDR_W     (AW),
    .N_PIXELS   (N),
    .READ_LAT   (RL),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .threshold (threshold),
    .busy      (busy),
    .done      (done),
    .bram_en   (bram_en),
    .bram_addr (bram_addr),
    .bram_dout (bram_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_gray    (m_gray),
    .m_bit     (m_bit),
    .m_last    (m_last),
    .m_index   (m_index),
    .on_count  (on_count)
  );

  // BRAM model: word appears RL cycles after the enable, garbage otherwise.
  logic [15:0] mem [N];
  logic [15:0] p1 = 16'hDEAD;
  logic [15:0] p2 = 16'hDEAD;
  always @(posedge clk) begin
    p1 <= bram_en ? mem[bram_addr] : 16'hDEAD;
    p2 <= p1;
  end
  assign bram_dout = (RL == 1) ? p1 : p2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned duty = 100;
  logic        hold_low = 1'b0;
  always @(posedge clk) begin
    #1;
    m_ready = hold_low ? 1'b0 : ($urandom_range(0, 99) < duty);
  end

  // Monitor: records handshakes and protocol observations at negedge.
  logic [19:0] got[$];
  logic [19:0] exp_q[$];
  int exp_on;
  int issued = 0, popped = 0, cur_out = 0, max_out = 0;
  int credit_viol = 0, en_viol = 0, stab_viol = 0, n_done = 0, last_hs = 0;
  logic prev_stall = 1'b0;
  logic [19:0] held = '0;
  int n_cmp = 0, n_fail = 0;
  int c0 = 0;

  always @(negedge clk) begin
    if (reset) begin
      issued = 0;
      popped = 0;
      prev_stall = 1'b0;
    end else begin
      cur_out = issued - popped;
      if (cur_out > max_out) max_out = cur_out;
      if (bram_en) begin
        if (cur_out + 1 > DEPTH) credit_viol++;
        if (!busy) en_viol++;
        issued++;
      end
      if (prev_stall && ({m_gray, m_bit, m_last, m_index} !== held)) stab_viol++;
      if (m_valid && m_ready) begin
        got.push_back({m_gray, m_bit, m_last, m_index});
        popped++;
        last_hs = cyc;
      end
      prev_stall = m_valid && !m_ready;
      held = {m_gray, m_bit, m_last, m_index};
      if (done) n_done++;
    end
  end

  // Reference: gray = 2R + G + 2B with the frame's threshold.
  function automatic void build_exp(input logic [7:0] thr);
    int g;
    logic [15:0] w;
    exp_q.delete();
    exp_on = 0;
    for (int i = 0; i < N; i++) begin
      w = mem[i];
      g = 2 * int'(w[15:11]) + int'(w[10:5]) + 2 * int'(w[4:0]);
      if (g >= int'(thr)) exp_on++;
      exp_q.push_back({8'(g), (g >= int'(thr)), (i == N - 1), 10'(i)});
    end
  endfunction

  function automatic int stream_bad();
    int bad;
    bad = (got.size() > exp_q.size()) ? got.size() - exp_q.size()
                                      : exp_q.size() - got.size();
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) bad++;
    return bad;
  endfunction

  function automatic logic [44:0] out_vec();
    return {busy, done, bram_en, bram_addr, m_valid, m_gray, m_bit, m_last,
            m_index, on_count};
  endfunction

  task automatic fill_random();
    for (int i = 0; i < N; i++) mem[i] = 16'($urandom);
  endtask

  task automatic begin_frame(input logic [7:0] thr);
    @(posedge clk); #1;
    got.delete();
    credit_viol = 0; en_viol = 0; stab_viol = 0; max_out = 0; n_done = 0;
    start = 1'b1;
    threshold = thr;
    c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    threshold = 8'($urandom);
  endtask

  task automatic wait_done(output logic to);
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (done) break;
    end
    to = !done;
  endtask

  task automatic wait_pixels(input int n, output logic to);
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (got.size() >= n) break;
    end
    to = (got.size() < n);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_vec() !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0", out_vec());
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_linear();
    logic to;
    int dcyc;
    for (int i = 0; i < N; i++) mem[i] = 16'(i);
    duty = 100;
    build_exp(8'd0);
    begin_frame(8'd0);
    wait_done(to);
    dcyc = cyc;
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL linear_timeout: no done, required done"); end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL linear_busy_at_done: got %b, required 0", busy); end
    n_cmp++;
    if (dcyc !== c0 + 2 + RL + N) begin
      n_fail++; $display("FAIL linear_done_cycle: got %0d, required %0d", dcyc - c0, 2 + RL + N);
    end
    n_cmp++;
    if (last_hs !== c0 + 1 + RL + N) begin
      n_fail++; $display("FAIL linear_last_hs_cycle: got %0d, required %0d", last_hs - c0, 1 + RL + N);
    end
    repeat (3) @(negedge clk); #1;
    n_cmp++;
    if (stream_bad() !== 0) begin
      n_fail++; $display("FAIL linear_stream: %0d bad of %0d received, required 0 bad of %0d", stream_bad(), got.size(), N);
    end
    n_cmp++;
    if (on_count !== 11'(exp_on)) begin
      n_fail++; $display("FAIL linear_on_count: got %0d, required %0d", on_count, exp_on);
    end
    n_cmp++;
    if (n_done !== 1) begin n_fail++; $display("FAIL linear_done_pulses: got %0d, required 1", n_done); end
    n_cmp++;
    if (en_viol !== 0) begin n_fail++; $display("FAIL linear_en_outside_busy: got %0d, required 0", en_viol); end
  endtask

  task automatic test_colors();
    logic to;
    logic [3:0] bits;
    fill_random();
    mem[0] = 16'hFFFF; mem[1] = 16'h0000; mem[2] = 16'hF800; mem[3] = 16'h07E0;
    duty = 100;
    build_exp(8'd63);
    begin_frame(8'd63);
    wait_done(to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL colors_timeout: no done, required done"); end
    @(negedge clk);
    bits = '0;
    for (int i = 0; i < 4 && i < got.size(); i++) bits[3 - i] = got[i][11];
    n_cmp++;
    if (bits !== 4'b1001) begin n_fail++; $display("FAIL colors_bits: got %b, required 1001", bits); end
    n_cmp++;
    if (stream_bad() !== 0) begin
      n_fail++; $display("FAIL colors_stream: %0d bad of %0d received, required 0 bad of %0d", stream_bad(), got.size(), N);
    end
    n_cmp++;
    if (on_count !== 11'(exp_on)) begin
      n_fail++; $display("FAIL colors_on_count: got %0d, required %0d", on_count, exp_on);
    end
  endtask

  task automatic test_backpressure();
    logic to;
    logic [7:0] thr;
    fill_random();
    thr = 8'($urandom_range(0, 189));
    duty = 30;
    build_exp(thr);
    begin_frame(thr);
    wait_done(to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL bp_timeout: no done, required done"); end
    repeat (3) @(negedge clk); #1;
    duty = 100;
    n_cmp++;
    if (stream_bad() !== 0) begin
      n_fail++; $display("FAIL bp_stream: %0d bad of %0d received, required 0 bad of %0d", stream_bad(), got.size(), N);
    end
    n_cmp++;
    if (on_count !== 11'(exp_on)) begin
      n_fail++; $display("FAIL bp_on_count: got %0d, required %0d", on_count, exp_on);
    end
    n_cmp++;
    if (credit_viol !== 0) begin n_fail++; $display("FAIL bp_credit: got %0d violations, required 0", credit_viol); end
    n_cmp++;
    if (max_out > DEPTH) begin n_fail++; $display("FAIL bp_occupancy: got %0d, required <= %0d", max_out, DEPTH); end
    n_cmp++;
    if (stab_viol !== 0) begin n_fail++; $display("FAIL bp_stability: got %0d changes, required 0", stab_viol); end
    n_cmp++;
    if (n_done !== 1) begin n_fail++; $display("FAIL bp_done_pulses: got %0d, required 1", n_done); end
  endtask

  task automatic test_start_ignored();
    logic to;
    logic [7:0] thr;
    fill_random();
    thr = 8'($urandom_range(40, 140));
    duty = 100;
    build_exp(thr);
    begin_frame(thr);
    wait_pixels(100, to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL ign_progress_timeout: got %0d pixels, required 100", got.size()); end
    @(posedge clk); #1;
    start = 1'b1;
    threshold = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL ign_timeout: no done, required done"); end
    repeat (4) @(negedge clk); #1;
    n_cmp++;
    if (stream_bad() !== 0) begin
      n_fail++; $display("FAIL ign_stream: %0d bad of %0d received, required 0 bad of %0d", stream_bad(), got.size(), N);
    end
    n_cmp++;
    if (n_done !== 1) begin n_fail++; $display("FAIL ign_done_pulses: got %0d, required 1", n_done); end
    n_cmp++;
    if (on_count !== 11'(exp_on)) begin
      n_fail++; $display("FAIL ign_on_count: got %0d, required %0d", on_count, exp_on);
    end
  endtask

  task automatic test_reset_mid();
    logic to;
    logic [7:0] thr;
    fill_random();
    thr = 8'($urandom_range(40, 140));
    duty = 100;
    build_exp(thr);
    begin_frame(thr);
    wait_pixels(500, to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL rst_progress_timeout: got %0d pixels, required 500", got.size()); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_vec() !== '0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got %h, required 0", out_vec());
    end
    begin_frame(thr);
    wait_done(to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL rst_restream_timeout: no done, required done"); end
    @(negedge clk);
    n_cmp++;
    if (stream_bad() !== 0) begin
      n_fail++; $display("FAIL rst_restream: %0d bad of %0d received, required 0 bad of %0d", stream_bad(), got.size(), N);
    end
    n_cmp++;
    if (on_count !== 11'(exp_on)) begin
      n_fail++; $display("FAIL rst_on_count: got %0d, required %0d", on_count, exp_on);
    end
  endtask

  task automatic test_stall();
    logic to;
    logic [7:0] thr;
    fill_random();
    thr = 8'($urandom_range(40, 140));
    duty = 100;
    build_exp(thr);
    begin_frame(thr);
    wait_pixels(300, to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL stall_progress_timeout: got %0d pixels, required 300", got.size()); end
    hold_low = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    n_cmp++;
    if (cur_out !== DEPTH) begin n_fail++; $display("FAIL stall_outstanding: got %0d, required %0d", cur_out, DEPTH); end
    n_cmp++;
    if (bram_en !== 1'b0) begin n_fail++; $display("FAIL stall_bram_en: got %b, required 0", bram_en); end
    hold_low = 1'b0;
    wait_done(to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL stall_timeout: no done, required done"); end
    @(negedge clk); #1;
    n_cmp++;
    if (stream_bad() !== 0) begin
      n_fail++; $display("FAIL stall_stream: %0d bad of %0d received, required 0 bad of %0d", stream_bad(), got.size(), N);
    end
    n_cmp++;
    if (stab_viol !== 0) begin n_fail++; $display("FAIL stall_stability: got %0d changes, required 0", stab_viol); end
    n_cmp++;
    if (credit_viol !== 0) begin n_fail++; $display("FAIL stall_credit: got %0d violations, required 0", credit_viol); end
  endtask

  task automatic test_back_to_back();
    logic to;
    logic [7:0] thr2;
    fill_random();
    duty = 100;
    build_exp(8'd90);
    begin_frame(8'd90);
    wait_done(to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL b2b_first_timeout: no done, required done"); end
    n_cmp++;
    if (stream_bad() !== 0) begin
      n_fail++; $display("FAIL b2b_first_stream: %0d bad of %0d received, required 0 bad of %0d", stream_bad(), got.size(), N);
    end
    thr2 = 8'($urandom_range(0, 189));
    build_exp(thr2);
    begin_frame(thr2);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_start_accept: busy %b, required 1", busy); end
    wait_done(to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL b2b_second_timeout: no done, required done"); end
    @(negedge clk);
    n_cmp++;
    if (stream_bad() !== 0) begin
      n_fail++; $display("FAIL b2b_second_stream: %0d bad of %0d received, required 0 bad of %0d", stream_bad(), got.size(), N);
    end
    n_cmp++;
    if (on_count !== 11'(exp_on)) begin
      n_fail++; $display("FAIL b2b_on_count: got %0d, required %0d", on_count, exp_on);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_linear();
    test_colors();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_stall();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
